ram_wr_scheduler: RTL and testbench

Write-port scheduler in front of the 8R8W live-value-table RAM. It owns all eight RAM write ports. After reset, or on request, it clears the whole array to zero. It then accepts up to eight write requests per cycle over valid/ready and guarantees that no two RAM write ports ever carry the same address in one cycle, since the LVT cannot resolve that case. Same-address collisions are resolved by a rotating priority; losing requesters stall.

---
 rtl/ram_pkg.sv | 27 ++
 rtl/wr_conflict_resolve.sv | 39 +++
 rtl/ram_wr_scheduler.sv | 123 ++++++++++++
 tb/tb_ram_wr_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// ============================================================================
// ram_pkg : shared constants, FSM state type and priority-rank helper for
//           the RAM write-port scheduler.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ram_pkg;

  localparam int BLOCKSIZE = 10;
  localparam int AW        = BLOCKSIZE + 1;
  localparam int DW        = 32;
  localparam int NPORT     = 8;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Rank 0 is the highest-priority requester; wraps modulo 8.
  function automatic logic [2:0] prio_rank(input logic [2:0] idx, input logic [2:0] prio);
    return idx - prio;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wr_conflict_resolve.sv
// ============================================================================
// wr_conflict_resolve : combinational same-address arbitration; a requester
//                       is granted unless a higher-ranked candidate shares
//                       its address.
// Revision: 1.0
// ============================================================================
`default_nettype none

module wr_conflict_resolve #(
  parameter int AW    = ram_pkg::AW,
  parameter int NPORT = ram_pkg::NPORT
) (
  input  logic [NPORT-1:0]    valid,
  input  logic [NPORT*AW-1:0] addrs,
  input  logic [2:0]          prio,
  output logic [NPORT-1:0]    grant
);

  import ram_pkg::*;

  // beaten_by[i][j]: requester j blocks requester i
  logic [NPORT-1:0][NPORT-1:0] beaten_by;

  for (genvar i = 0; i < NPORT; i++) begin : g_row
    for (genvar j = 0; j < NPORT; j++) begin : g_col
      if (i == j) begin : g_self
        assign beaten_by[i][j] = 1'b0;
      end else begin : g_other
        assign beaten_by[i][j] = valid[j]
                               && (addrs[j*AW +: AW] == addrs[i*AW +: AW])
                               && (prio_rank(3'(j), prio) < prio_rank(3'(i), prio));
      end
    end
    assign grant[i] = valid[i] & ~(|beaten_by[i]);
  end

endmodule

`default_nettype wire

// File: rtl/ram_wr_scheduler.sv
// ============================================================================
// ram_wr_scheduler : owns the eight LVT RAM write ports; clears the array
//                    after reset / init_req, then schedules collision-free
//                    writes from eight valid/ready requesters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram_wr_scheduler #(
  parameter int BLOCKSIZE = ram_pkg::BLOCKSIZE,
  parameter int DW        = ram_pkg::DW,
  parameter int NPORT     = ram_pkg::NPORT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NPORT-1:0]               req_valid,
  input  logic [NPORT*(BLOCKSIZE+1)-1:0] req_addr,
  input  logic [NPORT*DW-1:0]            req_data,
  output logic [NPORT-1:0]               req_ready,
  input  logic                           init_req,
  output logic                           init_done,
  output logic [NPORT-1:0]               w_enb,
  output logic [NPORT*(BLOCKSIZE+1)-1:0] w_addr,
  output logic [NPORT*DW-1:0]            w_din
);

  import ram_pkg::*;

  localparam int AW = BLOCKSIZE + 1;
  localparam int CW = AW - 3;

  state_t              state, state_nxt;
  logic [CW-1:0]       clr_ptr, clr_ptr_nxt;
  logic [2:0]          prio, prio_nxt;
  logic [NPORT-1:0]    grant;
  logic [NPORT-1:0]    ready_int;
  logic [NPORT-1:0]    w_enb_nxt;
  logic [NPORT*AW-1:0] w_addr_nxt;
  logic [NPORT*AW-1:0] init_addr;
  logic [NPORT*DW-1:0] w_din_nxt;
  logic                any_loser;

  wr_conflict_resolve #(
    .AW    (AW),
    .NPORT (NPORT)
  ) u_resolve (
    .valid (req_valid),
    .addrs (req_addr),
    .prio  (prio),
    .grant (grant)
  );

  assign any_loser = |(req_valid & ~grant);

  // Each port clears its own residue class, so clear writes never collide.
  for (genvar i = 0; i < NPORT; i++) begin : g_init_addr
    assign init_addr[i*AW +: AW] = {clr_ptr, 3'(i)};
  end

  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    prio_nxt    = prio;
    ready_int   = '0;
    w_enb_nxt   = '0;
    w_addr_nxt  = w_addr;
    w_din_nxt   = w_din;
    case (state)
      INIT: begin
        w_enb_nxt   = '1;
        w_addr_nxt  = init_addr;
        w_din_nxt   = '0;
        clr_ptr_nxt = clr_ptr + 1'b1;
        if (&clr_ptr) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (init_req) begin
          state_nxt   = INIT;
          clr_ptr_nxt = '0;
        end else begin
          ready_int = grant;
        end
        if (any_loser) begin
          prio_nxt = prio + 1'b1;
        end
        w_enb_nxt = ready_int;
        for (int i = 0; i < NPORT; i++) begin
          if (ready_int[i]) begin
            w_addr_nxt[i*AW +: AW] = req_addr[i*AW +: AW];
            w_din_nxt[i*DW +: DW]  = req_data[i*DW +: DW];
          end
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= INIT;
      clr_ptr <= '0;
      prio    <= '0;
      w_enb   <= '0;
      w_addr  <= '0;
      w_din   <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
      prio    <= prio_nxt;
      w_enb   <= w_enb_nxt;
      w_addr  <= w_addr_nxt;
      w_din   <= w_din_nxt;
    end
  end

  assign req_ready = ready_int;
  assign init_done = (state == RUN);

endmodule

`default_nettype wire

// File: tb/tb_ram_wr_scheduler.sv
// ============================================================================
// tb_ram_wr_scheduler : self-checking bench for ram_wr_scheduler.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ram_wr_scheduler;

  localparam int AW = 11;
  localparam int DW = 32;
  localparam int NP = 8;
  localparam int NCLR = 256;

  logic            clk;
  logic            rst;
  logic [NP-1:0]   req_valid;
  logic [NP*AW-1:0] req_addr;
  logic [NP*DW-1:0] req_data;
  logic [NP-1:0]   req_ready;
  logic            init_req;
  logic            init_done;
  logic [NP-1:0]   w_enb;
  logic [NP*AW-1:0] w_addr;
  logic [NP*DW-1:0] w_din;

  logic [AW-1:0] r_addr [NP];
  logic [DW-1:0] r_data [NP];

  ram_wr_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .init_req  (init_req),
    .init_done (init_done),
    .w_enb     (w_enb),
    .w_addr    (w_addr),
    .w_din     (w_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < NP; i++) begin
      req_addr[i*AW +: AW] = r_addr[i];
      req_data[i*DW +: DW] = r_data[i];
    end
  end

  // Reference model state
  bit            m_run;
  int            m_clr;
  int            m_prio;
  logic [NP-1:0] m_wenb;
  logic [NP-1:0] m_last_rdy;
  logic [AW-1:0] m_addr [NP];
  logic [DW-1:0] m_din  [NP];

  int  n_pass;
  int  n_checks;
  bit  cov_on;
  int  cov_cnt [2048];
  int  cov_bad;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scan requesters in priority order; the first one seen at an address wins it.
  function automatic logic [NP-1:0] ref_grant(input logic [NP-1:0] v, input int pr);
    logic [NP-1:0] g;
    int            seen[$];
    int            p;
    bit            hit;
    g = '0;
    for (int k = 0; k < NP; k++) begin
      p = (pr + k) % NP;
      if (v[p]) begin
        hit = 0;
        foreach (seen[s]) if (seen[s] == int'(r_addr[p])) hit = 1;
        if (!hit) begin
          g[p] = 1'b1;
          seen.push_back(int'(r_addr[p]));
        end
      end
    end
    return g;
  endfunction

  task automatic model_reset();
    m_run = 0; m_clr = 0; m_prio = 0; m_wenb = '0; m_last_rdy = '0;
    for (int i = 0; i < NP; i++) begin
      m_addr[i] = '0;
      m_din[i]  = '0;
    end
  endtask

  task automatic step(output logic [NP-1:0] rdy_seen);
    logic [NP-1:0]    g, er;
    logic [NP*AW-1:0] ea;
    logic [NP*DW-1:0] ed;
    bit               dup;
    g  = ref_grant(req_valid, m_prio);
    er = (m_run && !init_req) ? g : '0;
    #1;
    rdy_seen = req_ready;
    check("req_ready", req_ready, er);
    @(posedge clk);
    if (!m_run) begin
      m_wenb = '1;
      for (int i = 0; i < NP; i++) begin
        m_addr[i] = AW'(m_clr * NP + i);
        m_din[i]  = '0;
      end
      if (m_clr == NCLR - 1) m_run = 1;
      m_clr = (m_clr + 1) % NCLR;
    end else begin
      m_wenb = er;
      for (int i = 0; i < NP; i++) begin
        if (er[i]) begin
          m_addr[i] = r_addr[i];
          m_din[i]  = r_data[i];
        end
      end
      if ((req_valid & ~g) != '0) m_prio = (m_prio + 1) % NP;
      if (init_req) begin
        m_run = 0;
        m_clr = 0;
      end
    end
    m_last_rdy = er;
    #1;
    for (int i = 0; i < NP; i++) begin
      ea[i*AW +: AW] = m_addr[i];
      ed[i*DW +: DW] = m_din[i];
    end
    check("w_enb", w_enb, m_wenb);
    check("w_addr", w_addr, ea);
    check("w_din", w_din, ed);
    check("init_done", init_done, m_run);
    dup = 0;
    for (int i = 0; i < NP; i++)
      for (int j = i + 1; j < NP; j++)
        if (w_enb[i] && w_enb[j] && w_addr[i*AW +: AW] == w_addr[j*AW +: AW]) dup = 1;
    check("dup_addr", dup, 0);
    if (cov_on) begin
      for (int i = 0; i < NP; i++) begin
        if (w_enb[i]) begin
          cov_cnt[w_addr[i*AW +: AW]]++;
          if (w_din[i*DW +: DW] != '0) cov_bad++;
        end
      end
    end
  endtask

  // Full clear: every address written exactly once with zero, ready held low.
  task automatic run_clear(input bit poke_init);
    logic [NP-1:0] rs;
    int            once;
    foreach (cov_cnt[a]) cov_cnt[a] = 0;
    cov_bad = 0;
    cov_on  = 1;
    for (int c = 0; c < NCLR; c++) begin
      init_req = poke_init ? ($urandom_range(0, 15) == 0) : 1'b0;
      step(rs);
    end
    init_req = 1'b0;
    cov_on   = 0;
    once = 0;
    foreach (cov_cnt[a]) if (cov_cnt[a] == 1) once++;
    check("clear_cover", once, 2048);
    check("clear_data", cov_bad, 0);
  endtask

  typedef struct {
    logic [NP-1:0] valid;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;
    logic [NP-1:0] use_b;
    logic [DW-1:0] data_base;
    logic [NP-1:0] exp_ready;
  } vec_t;

  vec_t tbl [14];

  task automatic apply_vec(input vec_t v);
    for (int i = 0; i < NP; i++) begin
      req_valid[i] = v.valid[i];
      r_addr[i]    = v.use_b[i] ? v.addr_b : v.addr_a + AW'(i);
      r_data[i]    = v.data_base + DW'(i);
    end
  endtask

  initial begin
    logic [NP-1:0] rs;
    n_pass = 0; n_checks = 0; cov_on = 0; cov_bad = 0;
    init_req = 1'b0;
    req_valid = '0;
    for (int i = 0; i < NP; i++) begin
      r_addr[i] = AW'(i);
      r_data[i] = '0;
    end

    tbl[0]  = '{8'hFF, 11'h010, 11'h000, 8'h00, 32'hA0,  8'hFF};
    tbl[1]  = '{8'hA4, 11'h000, 11'h3FF, 8'hA4, 32'h100, 8'h04};
    tbl[2]  = '{8'hA0, 11'h000, 11'h3FF, 8'hA0, 32'h100, 8'h20};
    tbl[3]  = '{8'h80, 11'h000, 11'h3FF, 8'h80, 32'h100, 8'h80};
    tbl[4]  = '{8'h03, 11'h000, 11'h100, 8'h03, 32'h200, 8'h01};
    tbl[5]  = '{8'h02, 11'h000, 11'h100, 8'h03, 32'h200, 8'h02};
    tbl[6]  = '{8'h03, 11'h000, 11'h100, 8'h03, 32'h300, 8'h01};
    tbl[7]  = '{8'h02, 11'h000, 11'h100, 8'h03, 32'h300, 8'h02};
    tbl[8]  = '{8'h03, 11'h000, 11'h100, 8'h03, 32'h400, 8'h01};
    tbl[9]  = '{8'h02, 11'h000, 11'h100, 8'h03, 32'h400, 8'h02};
    tbl[10] = '{8'h03, 11'h000, 11'h100, 8'h03, 32'h500, 8'h01};
    tbl[11] = '{8'h02, 11'h000, 11'h100, 8'h03, 32'h500, 8'h02};
    tbl[12] = '{8'h42, 11'h000, 11'h005, 8'h42, 32'h600, 8'h40};
    tbl[13] = '{8'h02, 11'h000, 11'h005, 8'h42, 32'h600, 8'h02};

    // Reset state
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    check("rst_w_enb", w_enb, 0);
    check("rst_w_addr", w_addr, 0);
    check("rst_w_din", w_din, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_init_done", init_done, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Clear with every requester asking; none may be granted until RUN.
    req_valid = '1;
    run_clear(1'b0);
    req_valid = '0;

    for (int t = 0; t < 14; t++) begin
      apply_vec(tbl[t]);
      step(rs);
      check($sformatf("tbl%0d_ready", t), rs, tbl[t].exp_ready);
    end

    // init_req in RUN with all requesters valid
    for (int i = 0; i < NP; i++) begin
      req_valid[i] = 1'b1;
      r_addr[i]    = AW'(11'h020 + i);
      r_data[i]    = DW'(32'hC0 + i);
    end
    init_req = 1'b1;
    step(rs);
    check("initreq_ready", rs, 0);
    req_valid = '0;
    run_clear(1'b1);

    // Randomized traffic over a small address pool; stalled requests hold.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NP; i++) begin
        if (!(req_valid[i] && !m_last_rdy[i])) begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          r_addr[i]    = AW'(11'h700 + $urandom_range(0, 5));
          r_data[i]    = $urandom;
        end
      end
      step(rs);
    end

    // Reset mid-burst
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < NP; i++) begin
        req_valid[i] = 1'b1;
        r_addr[i]    = AW'(c * NP + i);
        r_data[i]    = $urandom;
      end
      step(rs);
    end
    #1 rst = 1'b0;
    #1;
    check("midrst_w_enb", w_enb, 0);
    check("midrst_req_ready", req_ready, 0);
    check("midrst_init_done", init_done, 0);
    model_reset();
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    run_clear(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
